// File: rtl/aes_panel_ctrl.sv
// Front-panel controller for the AES demo: button edge detection, preset select, encryptor launch and paged ciphertext display.
// Optional WAIT timeout with ERR state is enabled by defining PANEL_TIMEOUT_EN.
module aes_panel_ctrl #(
  parameter int DATA_W      = 128,
  parameter int DIGITS      = 8,
  parameter int NUM_PT      = 4,
  parameter int TIMEOUT_CYC = 1024,
  localparam int PAGES      = DATA_W / (4 * DIGITS),
  localparam int SEL_W      = (NUM_PT > 1) ? $clog2(NUM_PT) : 1,
  localparam int PAGE_W     = (PAGES > 1) ? $clog2(PAGES) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  btn_go_n,
  input  logic                  btn_sel_n,
  input  logic                  btn_page_n,
  output logic                  enc_load,
  output logic [SEL_W-1:0]      enc_pt_sel,
  input  logic [DATA_W-1:0]     enc_ct,
  input  logic                  enc_valid,
  output logic [4*DIGITS-1:0]   disp_data,
  output logic [PAGE_W-1:0]     disp_page,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int SLICE = 4 * DIGITS;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_SHOW
`ifdef PANEL_TIMEOUT_EN
    , S_ERR
`endif
  } state_e;

  state_e              state_q, state_d;
  logic                go_q, sel_btn_q, page_btn_q;
  logic [SEL_W-1:0]    sel_q, sel_d;
  logic [PAGE_W-1:0]   page_q, page_d;
  logic [DATA_W-1:0]   ct_q, ct_d;
  logic                load_q, busy_q, done_q;

  logic go_press, sel_press, page_press;
  assign go_press   = go_q & ~btn_go_n;
  assign sel_press  = sel_btn_q & ~btn_sel_n;
  assign page_press = page_btn_q & ~btn_page_n;

`ifdef PANEL_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q;
`endif

  // Preset index is frozen while an encryption is in flight
  always_comb begin
    sel_d = sel_q;
    if (sel_press && !(state_q == S_START || state_q == S_WAIT)) begin
      sel_d = (sel_q == SEL_W'(NUM_PT - 1)) ? '0 : sel_q + SEL_W'(1);
    end
    page_d = page_q;
    if (page_press) begin
      page_d = (page_q == '0) ? PAGE_W'(PAGES - 1) : page_q - PAGE_W'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    ct_d    = ct_q;
`ifdef PANEL_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      S_IDLE:  if (go_press) state_d = S_START;
      S_START: begin
        state_d = S_WAIT;
`ifdef PANEL_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      S_WAIT: begin
        if (enc_valid) begin
          ct_d    = enc_ct;
          state_d = S_SHOW;
        end
`ifdef PANEL_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) state_d = S_ERR;
        else cnt_d = cnt_q + CNT_W'(1);
`endif
      end
      S_SHOW:  if (go_press) state_d = S_START;
`ifdef PANEL_TIMEOUT_EN
      S_ERR:   if (go_press) state_d = S_START;
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // Status outputs are registered from next state so they align with the state they describe
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      go_q       <= 1'b1;
      sel_btn_q  <= 1'b1;
      page_btn_q <= 1'b1;
      sel_q      <= '0;
      page_q     <= PAGE_W'(PAGES - 1);
      ct_q       <= '0;
      load_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      go_q       <= btn_go_n;
      sel_btn_q  <= btn_sel_n;
      page_btn_q <= btn_page_n;
      sel_q      <= sel_d;
      page_q     <= page_d;
      ct_q       <= ct_d;
      load_q     <= (state_d == S_START);
      busy_q     <= (state_d == S_START) || (state_d == S_WAIT);
      done_q     <= (state_d == S_SHOW);
    end
  end

`ifdef PANEL_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= (state_d == S_ERR);
    end
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign enc_load   = load_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign enc_pt_sel = sel_q;
  assign disp_page  = page_q;
  assign disp_data  = ct_q[int'(page_q) * SLICE +: SLICE];

endmodule

// File: tb/tb_aes_panel_ctrl.sv
// Self-checking bench for aes_panel_ctrl: behavioural model with per-cycle compare plus directed literal checks.
module tb_aes_panel_ctrl;
  localparam int DATA_W  = 128;
  localparam int DIGITS  = 8;
  localparam int NUM_PT  = 4;
  localparam int TMO_CYC = 16;
  localparam int PAGES   = DATA_W / (4 * DIGITS);
`ifdef PANEL_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif
  localparam logic [127:0] CT1 = 128'h00112233_44556677_8899aabb_ccddeeff;
  localparam logic [127:0] CT2 = 128'hdeadbeef_01234567_89abcdef_cafef00d;
  localparam logic [127:0] CT3 = 128'h13579bdf_2468ace0_0f1e2d3c_4b5a6978;
  localparam int GO = 0, SEL = 1, PG = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         btn_go_n = 1'b1, btn_sel_n = 1'b1, btn_page_n = 1'b1;
  logic         enc_valid = 1'b0;
  logic [127:0] enc_ct = '0;
  logic         enc_load, busy, done, err;
  logic [1:0]   enc_pt_sel, disp_page;
  logic [31:0]  disp_data;

  aes_panel_ctrl #(.DATA_W(DATA_W), .DIGITS(DIGITS), .NUM_PT(NUM_PT), .TIMEOUT_CYC(TMO_CYC)) dut (
    .clk(clk), .rst(rst), .btn_go_n(btn_go_n), .btn_sel_n(btn_sel_n), .btn_page_n(btn_page_n),
    .enc_load(enc_load), .enc_pt_sel(enc_pt_sel), .enc_ct(enc_ct), .enc_valid(enc_valid),
    .disp_data(disp_data), .disp_page(disp_page), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Behavioural model: phases of one encryption request plus the user-visible indices
  bit           h_go, h_sel, h_pg;
  bit           m_load, m_wait, m_show, m_err;
  int           m_wcnt, m_sel, m_page;
  logic [127:0] m_ct;
  wire          gp = h_go  && !btn_go_n;
  wire          sp = h_sel && !btn_sel_n;
  wire          pp = h_pg  && !btn_page_n;
  wire [127:0]  m_sh = m_ct >> (32 * m_page);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      h_go <= 1'b1; h_sel <= 1'b1; h_pg <= 1'b1;
      m_load <= 1'b0; m_wait <= 1'b0; m_show <= 1'b0; m_err <= 1'b0;
      m_wcnt <= 0; m_sel <= 0; m_page <= PAGES - 1; m_ct <= '0;
    end else begin
      h_go <= btn_go_n; h_sel <= btn_sel_n; h_pg <= btn_page_n;
      if (sp && !(m_load || m_wait)) m_sel <= (m_sel + 1) % NUM_PT;
      if (pp) m_page <= (m_page + PAGES - 1) % PAGES;
      if (m_load) begin
        m_load <= 1'b0; m_wait <= 1'b1; m_wcnt <= 0;
      end else if (m_wait) begin
        if (enc_valid) begin
          m_ct <= enc_ct; m_wait <= 1'b0; m_show <= 1'b1;
        end else if (TMO_EN && (m_wcnt + 1 == TMO_CYC)) begin
          m_wait <= 1'b0; m_err <= 1'b1;
        end else begin
          m_wcnt <= m_wcnt + 1;
        end
      end else if (gp) begin
        m_load <= 1'b1; m_show <= 1'b0; m_err <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("m_enc_load", enc_load, m_load);
      chk("m_busy", busy, m_load || m_wait);
      chk("m_done", done, m_show);
      chk("m_err", err, m_err);
      chk("m_pt_sel", enc_pt_sel, 128'(m_sel));
      chk("m_page", disp_page, 128'(m_page));
      chk("m_disp_data", disp_data, m_sh[31:0]);
    end
  end

  task automatic drive(input int which, input logic v);
    case (which)
      GO:      btn_go_n = v;
      SEL:     btn_sel_n = v;
      default: btn_page_n = v;
    endcase
  endtask

  task automatic press(input int which, input int hold);
    @(negedge clk);
    drive(which, 1'b0);
    repeat (hold) @(negedge clk);
    drive(which, 1'b1);
  endtask

  task automatic respond(input int delay, input logic [127:0] ct);
    repeat (delay) @(negedge clk);
    enc_valid = 1'b1;
    enc_ct    = ct;
    @(negedge clk);
    enc_valid = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int exp_sel[5];
    exp_sel = '{1, 2, 3, 0, 1};
    repeat (3) @(negedge clk);
    chk("rst_load", enc_load, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_page", disp_page, 3);
    chk("rst_data", disp_data, 0);
    chk("rst_sel", enc_pt_sel, 0);
    #2 rst = 1'b0;
    @(negedge clk);

    // Encrypt, then page through the ciphertext
    press(GO, 1);
    chk("t1_load", enc_load, 1);
    chk("t1_busy", busy, 1);
    @(negedge clk);
    chk("t1_load_once", enc_load, 0);
    respond(10, CT1);
    chk("t1_done", done, 1);
    chk("t1_page3", disp_page, 3);
    chk("t1_d3", disp_data, 32'h00112233);
    press(PG, 1); chk("t1_d2", disp_data, 32'h44556677);
    press(PG, 1); chk("t1_d1", disp_data, 32'h8899aabb);
    press(PG, 1); chk("t1_d0", disp_data, 32'hccddeeff);
    press(PG, 1); chk("t1_wrap", disp_data, 32'h00112233);

    // Preset selection with wrap and a long hold
    for (int i = 0; i < 5; i++) begin
      press(SEL, 1);
      chk("t2_sel", enc_pt_sel, exp_sel[i]);
    end
    press(SEL, 50);
    chk("t2_hold", enc_pt_sel, 2);

    // Simultaneous sel+go from IDLE, then ignored presses while busy
    pulse_reset();
    @(negedge clk);
    btn_go_n = 1'b0; btn_sel_n = 1'b0;
    @(negedge clk);
    btn_go_n = 1'b1; btn_sel_n = 1'b1;
    chk("t3_load", enc_load, 1);
    chk("t3_sel_at_load", enc_pt_sel, 1);
    press(SEL, 1);
    press(GO, 1);
    chk("t3_no_reload", enc_load, 0);
    press(SEL, 3);
    chk("t3_sel_frozen", enc_pt_sel, 1);
    chk("t3_still_busy", busy, 1);
    respond(3, CT2);
    chk("t3_done", done, 1);
    chk("t3_data", disp_data, 32'hdeadbeef);

    // Asynchronous reset while waiting; a late valid must not complete
    press(PG, 1);
    chk("t4_page2", disp_data, 32'h01234567);
    press(GO, 1);
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("t4_busy", busy, 0);
    chk("t4_data", disp_data, 0);
    chk("t4_page", disp_page, 3);
    chk("t4_sel", enc_pt_sel, 0);
    @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    enc_valid = 1'b1; enc_ct = CT1;
    @(negedge clk);
    enc_valid = 1'b0;
    chk("t4_late_done", done, 0);
    @(negedge clk);
    chk("t4_late_data", disp_data, 0);

`ifdef PANEL_TIMEOUT_EN
    // Timeout into ERR, recovery by go
    press(GO, 1);
    chk("t5_load", enc_load, 1);
    repeat (16) @(negedge clk);
    chk("t5_err_pre", err, 0);
    chk("t5_busy_pre", busy, 1);
    @(negedge clk);
    chk("t5_err", err, 1);
    chk("t5_busy", busy, 0);
    press(SEL, 1);
    chk("t5_sel_in_err", enc_pt_sel, 1);
    press(GO, 1);
    chk("t5_reload", enc_load, 1);
    chk("t5_err_clr", err, 0);

    // Valid on the terminal-count cycle wins
    repeat (16) @(negedge clk);
    enc_valid = 1'b1; enc_ct = CT3;
    @(negedge clk);
    enc_valid = 1'b0;
    chk("t6_done", done, 1);
    chk("t6_err", err, 0);
    chk("t6_data", disp_data, 32'h13579bdf);
`endif

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
